// File: rtl/wb_scoreboard_pkg.sv
// Shared definitions for the writeback scoreboard.
//   err_cause_e : classification of a detected error, used to select what the
//                 first-error capture registers record.
//   clog2       : ceiling log2 for sizing pointers and counters.
package wb_scoreboard_pkg;

    typedef enum logic [1:0] {
        ERR_MISMATCH,
        ERR_UNDERFLOW,
        ERR_OVERFLOW,
        ERR_TIMEOUT
    } err_cause_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy count.
//   clk, rst (async, active high), clr (sync clear)
//   push/din  : write request; accepted when not full, or when full with a
//               simultaneous pop (occupancy stays the same)
//   pop/dout  : read request; dout always shows the head entry
//   full, empty, count : occupancy status
module wb_sync_fifo
    import wb_scoreboard_pkg::*;
#(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr;
    logic             rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr    = push && (!full || pop);
    assign rd    = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (wr && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_scoreboard.sv
// In-order writeback scoreboard.
// Queues expected register writes (exp_*) and matches each against the
// actual stage-3 writeback (S3_WE/S3_WS/ALUOut_valid).
//   clk, rst (async, active high), en (checking enable), clr (sync clear)
//   reg_file_error  : sticky any-error flag
//   err_pulse       : one-cycle strobe per error cycle
//   err_count       : saturating error count
//   first_err_*     : capture of the first failing write
//   overflow, underflow, timeout : sticky cause flags
//   pending         : queued entries
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 64,
    parameter bit          IGNORE_R0 = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    exp_we,
    input  logic [ADDR_W-1:0]       exp_ws,
    input  logic [DATA_W-1:0]       exp_wd,
    input  logic                    S3_WE,
    input  logic [ADDR_W-1:0]       S3_WS,
    input  logic [DATA_W-1:0]       ALUOut_valid,
    output logic                    reg_file_error,
    output logic                    err_pulse,
    output logic [CNT_W-1:0]        err_count,
    output logic                    first_err_valid,
    output logic [ADDR_W-1:0]       first_err_ws,
    output logic [DATA_W-1:0]       first_err_exp,
    output logic [DATA_W-1:0]       first_err_got,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    timeout,
    output logic [clog2(DEPTH):0]   pending
);

    localparam int unsigned TW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

    // Entry layout depends on module parameters, so it is declared here.
    typedef struct packed {
        logic [ADDR_W-1:0] ws;
        logic [DATA_W-1:0] wd;
    } wb_entry_t;

    wb_entry_t    head;
    wb_entry_t    push_entry;
    logic         full;
    logic         empty;
    logic         push_q;
    logic         pop_q;
    logic         bypass;
    logic         compare;
    logic         mismatch_ev;
    logic         underflow_ev;
    logic         overflow_ev;
    logic         tmo_hit;
    logic         any_err;
    logic [TW-1:0] tmo_cnt;
    logic [ADDR_W-1:0] cmp_ws;
    logic [DATA_W-1:0] cmp_wd;
    err_cause_e   cause;
    logic [ADDR_W-1:0] cap_ws;
    logic [DATA_W-1:0] cap_exp;
    logic [DATA_W-1:0] cap_got;

    assign push_q = en && exp_we && !(IGNORE_R0 && (exp_ws == '0));
    assign pop_q  = en && S3_WE  && !(IGNORE_R0 && (S3_WS  == '0));
    assign push_entry = '{ws: exp_ws, wd: exp_wd};

    // Same-cycle push and pop into an empty queue compares against the
    // incoming expectation and stores nothing.
    assign bypass  = push_q && pop_q && empty;
    assign compare = pop_q && (!empty || push_q);
    assign cmp_ws  = empty ? exp_ws : head.ws;
    assign cmp_wd  = empty ? exp_wd : head.wd;

    assign mismatch_ev  = compare && ((S3_WS != cmp_ws) || (ALUOut_valid != cmp_wd));
    assign underflow_ev = pop_q && empty && !push_q;
    assign overflow_ev  = push_q && full && !pop_q;
    assign tmo_hit      = en && (TIMEOUT != 0) && !pop_q && !empty &&
                          (tmo_cnt == TW'(TIMEOUT - 1));
    assign any_err      = mismatch_ev || underflow_ev || overflow_ev || tmo_hit;

    wb_sync_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push_q && !bypass),
        .pop   (pop_q && !empty),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    always_comb begin
        cause = ERR_OVERFLOW;
        if (mismatch_ev)       cause = ERR_MISMATCH;
        else if (underflow_ev) cause = ERR_UNDERFLOW;
        else if (tmo_hit)      cause = ERR_TIMEOUT;
    end

    always_comb begin
        cap_ws  = S3_WS;
        cap_exp = '0;
        cap_got = ALUOut_valid;
        case (cause)
            ERR_MISMATCH: begin
                cap_exp = cmp_wd;
            end
            ERR_UNDERFLOW: begin
                cap_exp = '0;
            end
            ERR_TIMEOUT: begin
                cap_ws  = head.ws;
                cap_exp = head.wd;
                cap_got = '0;
            end
            default: begin
                cap_ws  = exp_ws;
                cap_exp = exp_wd;
                cap_got = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_file_error  <= 1'b0;
            err_pulse       <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_ws    <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
            timeout         <= 1'b0;
            tmo_cnt         <= '0;
        end else if (clr) begin
            reg_file_error  <= 1'b0;
            err_pulse       <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_ws    <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
            timeout         <= 1'b0;
            tmo_cnt         <= '0;
        end else begin
            err_pulse <= any_err;
            if (any_err) begin
                reg_file_error <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_ws    <= cap_ws;
                    first_err_exp   <= cap_exp;
                    first_err_got   <= cap_got;
                end
            end
            if (overflow_ev)  overflow  <= 1'b1;
            if (underflow_ev) underflow <= 1'b1;
            if (tmo_hit)      timeout   <= 1'b1;
            // Counter saturates at TIMEOUT so only one error is raised per stall.
            if (en) begin
                if (pop_q || empty)
                    tmo_cnt <= '0;
                else if ((TIMEOUT != 0) && (tmo_cnt != TW'(TIMEOUT)))
                    tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule
